// File: rtl/bus_fabric_pkg.sv
// Shared types and the current system's memory map for the 6502 bus fabric.
// The optional unmapped-access fault logic in bus_fabric is enabled by defining BUS_FAULT_EN.
package bus_fabric_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [15:0] TIMER_BASE   = 16'hFE00;
    localparam logic [15:0] TIMER_MASK   = 16'hFFE0;
    localparam logic [15:0] UART_BASE    = 16'hFE20;
    localparam logic [15:0] UART_MASK    = 16'hFFE0;
    localparam logic [15:0] RGB_BASE     = 16'hFE40;
    localparam logic [15:0] RGB_MASK     = 16'hFFE0;
    localparam logic [15:0] VGA_BASE     = 16'hFE60;
    localparam logic [15:0] VGA_MASK     = 16'hFFE0;
    localparam logic [15:0] SPI_BASE     = 16'hFE80;
    localparam logic [15:0] SPI_MASK     = 16'hFFE0;
    localparam logic [15:0] PS2_BASE     = 16'hFEA0;
    localparam logic [15:0] PS2_MASK     = 16'hFFE0;
    localparam logic [15:0] ROM_BASE     = 16'hFF00;
    localparam logic [15:0] ROM_MASK     = 16'hFF00;
    // D000-EFFF is not a single aligned power-of-two block, so VRAM takes two windows.
    localparam logic [15:0] VRAM_LO_BASE = 16'hD000;
    localparam logic [15:0] VRAM_HI_BASE = 16'hE000;
    localparam logic [15:0] VRAM_MASK    = 16'hF000;

    localparam int DEF_N_SLAVES = 9;

    localparam logic [DEF_N_SLAVES*16-1:0] DEF_BASE = {
        VRAM_HI_BASE, VRAM_LO_BASE, ROM_BASE, PS2_BASE, SPI_BASE,
        VGA_BASE, RGB_BASE, UART_BASE, TIMER_BASE
    };

    localparam logic [DEF_N_SLAVES*16-1:0] DEF_MASK = {
        VRAM_MASK, VRAM_MASK, ROM_MASK, PS2_MASK, SPI_MASK,
        VGA_MASK, RGB_MASK, UART_MASK, TIMER_MASK
    };

endpackage

// File: rtl/bus_fabric_decode.sv
// Address window decode: per-window mask compare followed by a lowest-index-wins
// priority encoder, so overlapping windows resolve deterministically.
module bus_decode
    import bus_fabric_pkg::*;
#(
    parameter int                       N_SLAVES = 8,
    parameter int                       AW       = 16,
    parameter logic [N_SLAVES*AW-1:0]   SLV_BASE = {N_SLAVES*AW{1'b0}},
    parameter logic [N_SLAVES*AW-1:0]   SLV_MASK = {N_SLAVES*AW{1'b1}}
) (
    input  logic [AW-1:0]       addr,
    output logic [N_SLAVES-1:0] slv_sel,
    output logic                unmapped
);

    logic [N_SLAVES-1:0] hit;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_cmp
        assign hit[i] = (addr & SLV_MASK[i*AW +: AW]) ==
                        (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]);
    end

    // Scan from the top down so the last (lowest-index) hit is the one kept.
    always_comb begin
        slv_sel = '0;
        for (int j = N_SLAVES - 1; j >= 0; j--) begin
            if (hit[j]) begin
                slv_sel    = '0;
                slv_sel[j] = 1'b1;
            end
        end
    end

    assign unmapped = ~|hit;

endmodule

// File: rtl/bus_fabric.sv
// 6502 bus interconnect: CPU clock-enable divider, window decode, write strobes,
// registered read mux and per-window wait states. Fault capture is built only with BUS_FAULT_EN.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                           N_SLAVES = 8,
    parameter int                           AW       = 16,
    parameter int                           DW       = 8,
    parameter int                           CLK_DIV  = 2,
    parameter logic [N_SLAVES*AW-1:0]       SLV_BASE = {N_SLAVES*AW{1'b0}},
    parameter logic [N_SLAVES*AW-1:0]       SLV_MASK = {N_SLAVES*AW{1'b1}},
    parameter logic [N_SLAVES*WAIT_W-1:0]   SLV_WAIT = {N_SLAVES*WAIT_W{1'b0}}
) (
    input  logic                    clk25,
    input  logic                    rst,
    output logic                    cpu_ce,
    input  logic [AW-1:0]           addr,
    input  logic [DW-1:0]           dbw,
    input  logic                    we,
    output logic [DW-1:0]           dbr,
    output logic                    rdy,
    output logic [N_SLAVES-1:0]     slv_sel,
    output logic [N_SLAVES-1:0]     slv_we,
    input  logic [N_SLAVES*DW-1:0]  slv_dbr,
    output logic                    unmapped,
    output logic                    flt_irq,
    output logic [AW-1:0]           flt_addr,
    input  logic                    flt_clr
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic                rdy_q, rdy_d;
    logic                resume_q, resume_d;
    logic [WAIT_W-1:0]   wait_k;
    logic                stall_start;

    bus_decode #(
        .N_SLAVES (N_SLAVES),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr     (addr),
        .slv_sel  (slv_sel),
        .unmapped (unmapped)
    );

    assign cpu_ce = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q + 1'b1;
        if (cpu_ce) div_d = '0;
    end

    always_comb begin
        wait_k = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (slv_sel[i]) wait_k = wait_k | SLV_WAIT[i*WAIT_W +: WAIT_W];
        end
    end

    // resume_q marks the cycle in which a stalled access completes, so that
    // completion does not re-arm the stall for the same held access.
    assign stall_start = (state_q == ST_IDLE) && !resume_q && (wait_k != '0);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rdy_d    = rdy_q;
        resume_d = resume_q;
        if (cpu_ce) begin
            case (state_q)
                ST_IDLE: begin
                    resume_d = 1'b0;
                    if (stall_start) begin
                        state_d = ST_STALL;
                        wcnt_d  = wait_k;
                        rdy_d   = 1'b0;
                    end
                end
                ST_STALL: begin
                    wcnt_d = wcnt_q - 1'b1;
                    if (wcnt_q == WAIT_W'(1)) begin
                        state_d  = ST_IDLE;
                        rdy_d    = 1'b1;
                        resume_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (cpu_ce && rdy_q) sel_d = slv_sel;
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            sel_q    <= '0;
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            rdy_q    <= 1'b1;
            resume_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            sel_q    <= sel_d;
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rdy_q    <= rdy_d;
            resume_q <= resume_d;
        end
    end

    assign rdy = rdy_q;

    // A waited access must not strobe in its first cycle, only once rdy has come back.
    assign slv_we = {N_SLAVES{we & rdy_q & ~stall_start}} & slv_sel;

    always_comb begin
        dbr = '1;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) dbr = dbr & slv_dbr[i*DW +: DW];
        end
    end

    // Write data is wired straight from the CPU to every slave outside this block.
    logic unused_dbw;
    assign unused_dbw = ^dbw;

`ifdef BUS_FAULT_EN
    logic          flt_irq_q, flt_irq_d;
    logic [AW-1:0] flt_addr_q, flt_addr_d;

    always_comb begin
        flt_irq_d  = flt_irq_q;
        flt_addr_d = flt_addr_q;
        if (cpu_ce) begin
            if (flt_clr) begin
                flt_irq_d = 1'b0;
            end else if (unmapped && !flt_irq_q) begin
                flt_irq_d  = 1'b1;
                flt_addr_d = addr;
            end
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            flt_irq_q  <= 1'b0;
            flt_addr_q <= '0;
        end else begin
            flt_irq_q  <= flt_irq_d;
            flt_addr_q <= flt_addr_d;
        end
    end

    assign flt_irq  = flt_irq_q;
    assign flt_addr = flt_addr_q;
`else
    assign flt_irq  = 1'b0;
    assign flt_addr = '0;

    logic unused_clr;
    assign unused_clr = flt_clr;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Directed plus randomized bench for bus_fabric with an access-level reference model.
module tb_bus_fabric;

    localparam int N = 8, AW = 16, DW = 8, CLK_DIV = 2;

    // slot:                      7         6         5         4         3         2         1         0
    localparam logic [N*AW-1:0] P_BASE = {16'hC000, 16'hFF00, 16'hB000, 16'hA000, 16'h9000, 16'h8000, 16'hFE00, 16'hFE00};
    localparam logic [N*AW-1:0] P_MASK = {16'hF000, 16'hFF00, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hFF00, 16'hFFE0};
    localparam logic [N*4-1:0]  P_WAIT = {4'd0, 4'd2, 4'd0, 4'd1, 4'd5, 4'd3, 4'd0, 4'd0};

`ifdef BUS_FAULT_EN
    localparam bit FLT_EN = 1'b1;
`else
    localparam bit FLT_EN = 1'b0;
`endif

    logic              clk25 = 1'b0;
    logic              rst;
    logic              cpu_ce, rdy, we, unmapped, flt_irq, flt_clr;
    logic [AW-1:0]     addr, flt_addr;
    logic [DW-1:0]     dbw, dbr;
    logic [N-1:0]      slv_sel, slv_we;
    logic [N*DW-1:0]   slv_dbr;
    logic [DW-1:0]     mem [N];

    int                n_asrt, n_fail, prev_idx;
    logic              m_irq;
    logic [AW-1:0]     m_faddr;

    always #5 clk25 = ~clk25;

    always_comb begin
        slv_dbr = '0;
        for (int i = 0; i < N; i++) slv_dbr[i*DW +: DW] = mem[i];
    end

    bus_fabric #(
        .N_SLAVES (N), .AW (AW), .DW (DW), .CLK_DIV (CLK_DIV),
        .SLV_BASE (P_BASE), .SLV_MASK (P_MASK), .SLV_WAIT (P_WAIT)
    ) dut (
        .clk25 (clk25), .rst (rst), .cpu_ce (cpu_ce), .addr (addr), .dbw (dbw),
        .we (we), .dbr (dbr), .rdy (rdy), .slv_sel (slv_sel), .slv_we (slv_we),
        .slv_dbr (slv_dbr), .unmapped (unmapped), .flt_irq (flt_irq),
        .flt_addr (flt_addr), .flt_clr (flt_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First window whose masked compare matches, or -1 when unmapped.
    function automatic int ref_win(input logic [AW-1:0] a);
        for (int i = 0; i < N; i++)
            if ((a & P_MASK[i*AW +: AW]) == (P_BASE[i*AW +: AW] & P_MASK[i*AW +: AW])) return i;
        return -1;
    endfunction

    function automatic int ref_wait(input int idx);
        if (idx < 0) return 0;
        return int'(P_WAIT[idx*4 +: 4]);
    endfunction

    task automatic wait_ce();
        bit seen = 1'b0;
        for (int i = 0; i < 2*CLK_DIV + 2 && !seen; i++) begin
            @(negedge clk25);
            seen = (cpu_ce === 1'b1);
        end
        if (!seen) chk("ce_timeout", 32'd0, 32'd1);
    endtask

    // Called on the negedge before each CPU clock-enable edge.
    task automatic ce_tick();
        chk("flt_irq", flt_irq, m_irq);
        chk("flt_addr", flt_addr, m_faddr);
        if (FLT_EN) begin
            if (flt_clr) m_irq = 1'b0;
            else if (ref_win(addr) < 0 && !m_irq) begin
                m_irq   = 1'b1;
                m_faddr = addr;
            end
        end
    endtask

    task automatic sync_ce();
        wait_ce();
        ce_tick();
        prev_idx = ref_win(addr);
        @(posedge clk25); #1;
    endtask

    // One CPU access, entered just after a CPU clock-enable edge.
    task automatic do_access(input logic [AW-1:0] a, input logic w, input int fs, input logic [DW-1:0] fv);
        int idx, k, low;
        bit done;
        logic [N-1:0] oh, exp_we;
        addr = a; we = w; dbw = DW'($urandom);
        idx = ref_win(a);
        k   = ref_wait(idx);
        oh  = '0;
        if (idx >= 0) oh[idx] = 1'b1;
        @(negedge clk25);
        chk("dbr_prev", dbr, (prev_idx < 0) ? 8'hFF : mem[prev_idx]);
        chk("slv_sel", slv_sel, oh);
        chk("unmapped", unmapped, idx < 0);
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        if (fs >= 0) mem[fs] = fv;
        low = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            wait_ce();
            done   = (rdy === 1'b1) && (k == 0 || c > 0);
            exp_we = (done && w) ? oh : '0;
            chk("slv_we", slv_we, exp_we);
            if (rdy !== 1'b1) low++;
            ce_tick();
            @(posedge clk25); #1;
        end
        if (!done) chk("acc_timeout", 32'd0, 32'd1);
        chk("rdy_low_cycles", low, k);
        prev_idx = idx;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  nibs [8];
        nibs = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 4'h1, 4'h4};
        n_asrt = 0; n_fail = 0; prev_idx = -1; m_irq = 1'b0; m_faddr = '0;
        rst = 1'b1; addr = 16'h0000; we = 1'b0; dbw = '0; flt_clr = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);

        repeat (3) @(negedge clk25);
        chk("rst_ce", cpu_ce, 1'b0);
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_dbr", dbr, 8'hFF);
        chk("rst_flt_irq", flt_irq, 1'b0);
        chk("rst_flt_addr", flt_addr, 16'h0);
        chk("rst_slv_we", slv_we, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk25);
            chk("ce_pattern", cpu_ce, ((i + 1) % CLK_DIV) == CLK_DIV - 1);
            chk("idle_rdy", rdy, 1'b1);
            chk("idle_dbr", dbr, 8'hFF);
            if (((i + 1) % CLK_DIV) == CLK_DIV - 1) ce_tick();
        end
        sync_ce();

        do_access(16'hFE21, 1'b0, 1, 8'h5A);
        chk("uart_sel", slv_sel, 8'b0000_0010);
        chk("uart_dbr", dbr, 8'h5A);
        do_access(16'hFE10, 1'b0, -1, 8'h00);
        chk("prio_sel", slv_sel, 8'b0000_0001);

        do_access(16'h8123, 1'b1, -1, 8'h00);
        chk("w3_rdy_back", rdy, 1'b1);
        do_access(16'h8123, 1'b0, -1, 8'h00);
        do_access(16'h9004, 1'b0, -1, 8'h00);
        do_access(16'hA010, 1'b1, -1, 8'h00);
        do_access(16'hFF80, 1'b0, -1, 8'h00);
        do_access(16'hB000, 1'b1, -1, 8'h00);

        addr = 16'h9004; we = 1'b1;
        wait_ce(); chk("ms_rdy0", rdy, 1'b1); ce_tick(); @(posedge clk25); #1;
        for (int j = 0; j < 3; j++) begin
            wait_ce();
            chk("ms_stall_rdy", rdy, 1'b0);
            chk("ms_stall_we", slv_we, 8'h00);
            ce_tick();
            @(posedge clk25); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("ms_rst_rdy", rdy, 1'b1);
        chk("ms_rst_we", slv_we, 8'h00);
        chk("ms_rst_dbr", dbr, 8'hFF);
        m_irq = 1'b0; m_faddr = '0;
        repeat (2) @(negedge clk25);
        chk("ms_hold_we", slv_we, 8'h00);
        chk("ms_hold_ce", cpu_ce, 1'b0);
        addr = 16'hB000; we = 1'b0;
        rst = 1'b0;
        sync_ce();
        do_access(16'h9004, 1'b1, -1, 8'h00);

        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            do_access({nibs[$urandom_range(0, 7)], r[11:0]}, r[31], -1, 8'h00);
        end

        flt_clr = 1'b1; do_access(16'hFE21, 1'b0, -1, 8'h00); flt_clr = 1'b0;
        chk("clr0_irq", flt_irq, 1'b0);
        do_access(16'h1234, 1'b0, -1, 8'h00);
        chk("flt1_dbr", dbr, 8'hFF);
        chk("flt1_irq", flt_irq, FLT_EN);
        chk("flt1_addr", flt_addr, FLT_EN ? 16'h1234 : 16'h0000);
        do_access(16'h5678, 1'b0, -1, 8'h00);
        chk("flt2_dbr", dbr, 8'hFF);
        chk("flt2_irq", flt_irq, FLT_EN);
        chk("flt2_addr", flt_addr, FLT_EN ? 16'h1234 : 16'h0000);
        flt_clr = 1'b1; do_access(16'hFE21, 1'b0, -1, 8'h00); flt_clr = 1'b0;
        chk("clr1_irq", flt_irq, 1'b0);
        flt_clr = 1'b1; do_access(16'h4321, 1'b0, -1, 8'h00); flt_clr = 1'b0;
        chk("clr_wins_irq", flt_irq, 1'b0);
        do_access(16'h4321, 1'b0, -1, 8'h00);
        chk("flt3_irq", flt_irq, FLT_EN);
        chk("flt3_addr", flt_addr, FLT_EN ? 16'h4321 : 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
